multi_lane_instr_queue: RTL and testbench

Parametrised, in-order, multi-lane circular instruction buffer between the ID and IR stages. Accepts up to WIDTH instructions per cycle and presents the oldest WIDTH entries in parallel. Both push and pop counts are strict lane prefixes, so program order is preserved. Supports any depth >= WIDTH (non-power-of-two included), reports occupancy and free space, and asserts a programmable almost-full flag for front-end back-pressure.

---
 rtl/drac_pkg.sv | 37 +++
 rtl/multi_lane_instr_queue_if.sv | 29 ++
 rtl/multi_lane_instr_queue_lane_prefix_count.sv | 23 ++
 rtl/multi_lane_instr_queue.sv | 106 ++++++++++
 tb/tb_multi_lane_instr_queue.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/drac_pkg.sv
// Shared front-end constants and sizing helpers for the ID->IR instruction queue.
package drac_pkg;

    localparam int unsigned INSTRUCTION_QUEUE_NUM_ENTRIES = 32'd8;
    localparam int unsigned NUM_SCALAR_INSTR              = 32'd2;

    function automatic int unsigned ptr_w(input int unsigned depth);
        int unsigned w;
        if (depth > 32'd1) begin
            w = $clog2(depth);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // Non-power-of-two safe wrap: operands are below depth, so one subtract suffices.
    function automatic logic [31:0] wrap_add(input logic [31:0] ptr, input logic [31:0] k,
                                             input logic [31:0] depth);
        logic [31:0] sum;
        sum = ptr + k;
        if (sum >= depth) begin
            sum = sum - depth;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

    typedef logic [ptr_w(INSTRUCTION_QUEUE_NUM_ENTRIES)-1:0] iq_ptr_t;
    typedef logic [cnt_w(INSTRUCTION_QUEUE_NUM_ENTRIES)-1:0] iq_cnt_t;

endpackage

// File: rtl/multi_lane_instr_queue_if.sv
// Push/pop/status bundle of the multi-lane instruction queue.
interface multi_lane_instr_queue_if #(
    parameter int unsigned WIDTH  = 32'd2,
    parameter int unsigned DATA_W = 32'd128,
    parameter int unsigned CNT_W  = 32'd4
);
    logic                           flush_i;
    logic [WIDTH-1:0]               wr_valid_i;
    logic [WIDTH-1:0][DATA_W-1:0]   wr_data_i;
    logic [WIDTH-1:0]               wr_ready_o;
    logic [WIDTH-1:0][DATA_W-1:0]   rd_data_o;
    logic [WIDTH-1:0]               rd_valid_o;
    logic [WIDTH-1:0]               rd_pop_i;
    logic [CNT_W-1:0]               count_o;
    logic [CNT_W-1:0]               free_o;
    logic                           empty_o;
    logic                           full_o;
    logic                           almost_full_o;

    modport slave (
        input  flush_i, wr_valid_i, wr_data_i, rd_pop_i,
        output wr_ready_o, rd_data_o, rd_valid_o, count_o, free_o, empty_o, full_o, almost_full_o
    );

    modport master (
        output flush_i, wr_valid_i, wr_data_i, rd_pop_i,
        input  wr_ready_o, rd_data_o, rd_valid_o, count_o, free_o, empty_o, full_o, almost_full_o
    );
endinterface

// File: rtl/multi_lane_instr_queue_lane_prefix_count.sv
// Counts the leading run of ones from lane 0 upward.
module lane_prefix_count #(
    parameter int unsigned WIDTH = 32'd2,
    parameter int unsigned CNT_W = 32'd2
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_cnt
);
    logic w_run;

    // Stop counting at the first zero lane.
    always_comb begin
        o_cnt = '0;
        w_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_run && i_vec[i]) begin
                o_cnt = o_cnt + CNT_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/multi_lane_instr_queue.sv
// In-order multi-lane circular instruction buffer between the ID and IR stages.
module multi_lane_instr_queue
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH    = INSTRUCTION_QUEUE_NUM_ENTRIES,
    parameter int unsigned WIDTH    = NUM_SCALAR_INSTR,
    parameter int unsigned DATA_W   = 32'd128,
    parameter int unsigned AFULL_TH = 32'd2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    multi_lane_instr_queue_if.slave   q
);
    localparam int unsigned PTR_W  = ptr_w(DEPTH);
    localparam int unsigned CNT_W  = cnt_w(DEPTH);
    localparam int unsigned LANE_W = cnt_w(WIDTH);

    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_free;
    logic [CNT_W-1:0]  w_npush;
    logic [CNT_W-1:0]  w_npop;
    logic [LANE_W-1:0] w_push_run;
    logic [LANE_W-1:0] w_pop_run;
    logic [WIDTH-1:0]  w_rd_valid;
    logic [WIDTH-1:0]  w_pop_req;
    logic [PTR_W-1:0]  w_wr_idx [WIDTH];
    logic [PTR_W-1:0]  w_rd_idx [WIDTH];

    assign w_free    = CNT_W'(DEPTH) - r_count;
    assign w_pop_req = q.rd_pop_i & w_rd_valid;

    lane_prefix_count #(.WIDTH(WIDTH), .CNT_W(LANE_W)) u_push_cnt (
        .i_vec (q.wr_valid_i),
        .o_cnt (w_push_run)
    );

    lane_prefix_count #(.WIDTH(WIDTH), .CNT_W(LANE_W)) u_pop_cnt (
        .i_vec (w_pop_req),
        .o_cnt (w_pop_run)
    );

    // Accepted push count is capped by registered free space only (no pop credit).
    always_comb begin
        w_npush = '0;
        w_npop  = CNT_W'(w_pop_run);
        if (q.flush_i) begin
            w_npush = '0;
        end else if (CNT_W'(w_push_run) > w_free) begin
            w_npush = w_free;
        end else begin
            w_npush = CNT_W'(w_push_run);
        end
    end

    // Per-lane slot indices, read-side visibility and write handshake.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_wr_idx[i]     = PTR_W'(wrap_add(32'(r_tail), 32'(i), 32'(DEPTH)));
            w_rd_idx[i]     = PTR_W'(wrap_add(32'(r_head), 32'(i), 32'(DEPTH)));
            w_rd_valid[i]   = r_count > CNT_W'(i);
            q.wr_ready_o[i] = CNT_W'(i) < w_npush;
            if (w_rd_valid[i]) begin
                q.rd_data_o[i] = r_buf[w_rd_idx[i]];
            end else begin
                q.rd_data_o[i] = '0;
            end
        end
    end

    // Pointer and occupancy state; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (q.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= PTR_W'(wrap_add(32'(r_head), 32'(w_npop), 32'(DEPTH)));
            r_tail  <= PTR_W'(wrap_add(32'(r_tail), 32'(w_npush), 32'(DEPTH)));
            r_count <= r_count + w_npush - w_npop;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (CNT_W'(i) < w_npush) begin
                r_buf[w_wr_idx[i]] <= q.wr_data_i[i];
            end
        end
    end

    assign q.rd_valid_o    = w_rd_valid;
    assign q.count_o       = r_count;
    assign q.free_o        = w_free;
    assign q.empty_o       = (r_count == '0);
    assign q.full_o        = !rstn_i || (r_count == CNT_W'(DEPTH));
    assign q.almost_full_o = (w_free <= CNT_W'(AFULL_TH));
endmodule

// File: tb/tb_multi_lane_instr_queue.sv
// Directed bench for multi_lane_instr_queue: DEPTH=8 and DEPTH=6 instances, WIDTH=2.
module tb_multi_lane_instr_queue;
    localparam int DW = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    multi_lane_instr_queue_if #(.WIDTH(2), .DATA_W(DW), .CNT_W(4)) q8 ();
    multi_lane_instr_queue_if #(.WIDTH(2), .DATA_W(DW), .CNT_W(3)) q6 ();

    multi_lane_instr_queue #(.DEPTH(8), .WIDTH(2), .DATA_W(DW), .AFULL_TH(2)) u_dut8 (
        .clk_i (clk), .rstn_i (rstn), .q (q8)
    );
    multi_lane_instr_queue #(.DEPTH(6), .WIDTH(2), .DATA_W(DW), .AFULL_TH(2)) u_dut6 (
        .clk_i (clk), .rstn_i (rstn), .q (q6)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pl(input int n);
        return 32'hA000_0000 + n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q8.flush_i = 1'b0; q8.wr_valid_i = 2'b00; q8.rd_pop_i = 2'b00; q8.wr_data_i = '0;
        q6.flush_i = 1'b0; q6.wr_valid_i = 2'b00; q6.rd_pop_i = 2'b00; q6.wr_data_i = '0;
    endtask

    task automatic push8(input logic [1:0] v, input int a, input int b);
        q8.wr_valid_i = v; q8.wr_data_i[0] = pl(a); q8.wr_data_i[1] = pl(b); q8.rd_pop_i = 2'b00;
        tick();
        q8.wr_valid_i = 2'b00;
    endtask

    task automatic test_reset();
        idle();
        #1;
        n_checks++; if (q8.count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", q8.count_o); end
        n_checks++; if (q8.full_o !== 1'b1) begin n_fail++; $display("FAIL reset_full: got %b want 1", q8.full_o); end
        n_checks++; if (q8.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", q8.empty_o); end
        n_checks++; if (q8.free_o !== 4'd8) begin n_fail++; $display("FAIL reset_free: got %0d want 8", q8.free_o); end
        n_checks++; if (q8.almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", q8.almost_full_o); end
        n_checks++; if (q8.rd_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 00", q8.rd_valid_o); end
        n_checks++; if (q8.rd_data_o !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", q8.rd_data_o); end
        n_checks++; if (q6.full_o !== 1'b1) begin n_fail++; $display("FAIL reset_full6: got %b want 1", q6.full_o); end
        tick(); tick();
        rstn = 1'b1;
        #1;
        n_checks++; if (q8.full_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_full: got %b want 0", q8.full_o); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            q8.wr_valid_i = 2'b11; q8.wr_data_i[0] = pl(2*k); q8.wr_data_i[1] = pl(2*k+1);
            #1;
            n_checks++; if (q8.wr_ready_o !== 2'b11) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 11", k, q8.wr_ready_o); end
            tick();
            n_checks++; if (q8.count_o !== 4'(2*(k+1))) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, q8.count_o, 2*(k+1)); end
            if (k == 2) begin
                n_checks++; if (q8.almost_full_o !== 1'b1) begin n_fail++; $display("FAIL fill_afull6: got %b want 1", q8.almost_full_o); end
            end
            if (k == 1) begin
                n_checks++; if (q8.almost_full_o !== 1'b0) begin n_fail++; $display("FAIL fill_afull4: got %b want 0", q8.almost_full_o); end
            end
        end
        n_checks++; if (q8.full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", q8.full_o); end
        n_checks++; if (q8.free_o !== 4'd0) begin n_fail++; $display("FAIL fill_free: got %0d want 0", q8.free_o); end
        q8.wr_valid_i = 2'b11; q8.wr_data_i[0] = pl(90); q8.wr_data_i[1] = pl(91);
        #1;
        n_checks++; if (q8.wr_ready_o !== 2'b00) begin n_fail++; $display("FAIL full_ready: got %b want 00", q8.wr_ready_o); end
        tick();
        q8.wr_valid_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", q8.count_o); end
        n_checks++; if (q8.rd_data_o[0] !== pl(0) || q8.rd_data_o[1] !== pl(1)) begin
            n_fail++; $display("FAIL fill_rd_data: got %h %h want %h %h", q8.rd_data_o[0], q8.rd_data_o[1], pl(0), pl(1)); end
        n_checks++; if (q8.rd_valid_o !== 2'b11) begin n_fail++; $display("FAIL fill_rd_valid: got %b want 11", q8.rd_valid_o); end
    endtask

    task automatic test_full_push_pop();
        q8.wr_valid_i = 2'b11; q8.wr_data_i[0] = pl(92); q8.wr_data_i[1] = pl(93); q8.rd_pop_i = 2'b11;
        #1;
        n_checks++; if (q8.wr_ready_o !== 2'b00) begin n_fail++; $display("FAIL fpp_ready: got %b want 00", q8.wr_ready_o); end
        tick();
        n_checks++; if (q8.count_o !== 4'd6) begin n_fail++; $display("FAIL fpp_count: got %0d want 6", q8.count_o); end
        n_checks++; if (q8.rd_data_o[0] !== pl(2) || q8.rd_data_o[1] !== pl(3)) begin
            n_fail++; $display("FAIL fpp_head: got %h %h want %h %h", q8.rd_data_o[0], q8.rd_data_o[1], pl(2), pl(3)); end
        q8.rd_pop_i = 2'b00; q8.wr_data_i[0] = pl(8); q8.wr_data_i[1] = pl(9);
        #1;
        n_checks++; if (q8.wr_ready_o !== 2'b11) begin n_fail++; $display("FAIL fpp_next_ready: got %b want 11", q8.wr_ready_o); end
        tick();
        q8.wr_valid_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd8) begin n_fail++; $display("FAIL fpp_next_count: got %0d want 8", q8.count_o); end
        for (int k = 0; k < 4; k++) begin
            q8.rd_pop_i = 2'b11;
            #1;
            n_checks++; if (q8.rd_data_o[0] !== pl(2+2*k) || q8.rd_data_o[1] !== pl(3+2*k)) begin
                n_fail++; $display("FAIL fpp_drain[%0d]: got %h %h want %h %h", k, q8.rd_data_o[0], q8.rd_data_o[1], pl(2+2*k), pl(3+2*k)); end
            tick();
        end
        q8.rd_pop_i = 2'b00;
        n_checks++; if (q8.empty_o !== 1'b1 || q8.count_o !== 4'd0) begin
            n_fail++; $display("FAIL fpp_empty: got empty=%b count=%0d want 1/0", q8.empty_o, q8.count_o); end
    endtask

    task automatic test_partial_push();
        push8(2'b11, 10, 11); push8(2'b11, 12, 13); push8(2'b11, 14, 15);
        push8(2'b01, 16, 99);
        n_checks++; if (q8.count_o !== 4'd7) begin n_fail++; $display("FAIL part_count7: got %0d want 7", q8.count_o); end
        q8.wr_valid_i = 2'b11; q8.wr_data_i[0] = pl(17); q8.wr_data_i[1] = pl(98);
        #1;
        n_checks++; if (q8.wr_ready_o !== 2'b01) begin n_fail++; $display("FAIL part_ready: got %b want 01", q8.wr_ready_o); end
        tick();
        q8.wr_valid_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd8) begin n_fail++; $display("FAIL part_count8: got %0d want 8", q8.count_o); end
        for (int k = 0; k < 4; k++) begin
            q8.rd_pop_i = 2'b11;
            #1;
            n_checks++; if (q8.rd_data_o[0] !== pl(10+2*k) || q8.rd_data_o[1] !== pl(11+2*k)) begin
                n_fail++; $display("FAIL part_drain[%0d]: got %h %h want %h %h", k, q8.rd_data_o[0], q8.rd_data_o[1], pl(10+2*k), pl(11+2*k)); end
            tick();
        end
        q8.rd_pop_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd0) begin n_fail++; $display("FAIL part_end_count: got %0d want 0", q8.count_o); end
    endtask

    task automatic test_prefix();
        q8.wr_valid_i = 2'b10; q8.wr_data_i[0] = pl(96); q8.wr_data_i[1] = pl(97);
        #1;
        n_checks++; if (q8.wr_ready_o !== 2'b00) begin n_fail++; $display("FAIL pre_ready: got %b want 00", q8.wr_ready_o); end
        tick();
        q8.wr_valid_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd0) begin n_fail++; $display("FAIL pre_count0: got %0d want 0", q8.count_o); end
        push8(2'b11, 20, 21);
        q8.rd_pop_i = 2'b10;
        tick();
        n_checks++; if (q8.count_o !== 4'd2 || q8.rd_data_o[0] !== pl(20)) begin
            n_fail++; $display("FAIL pre_pop10: got count=%0d d0=%h want 2 %h", q8.count_o, q8.rd_data_o[0], pl(20)); end
        q8.rd_pop_i = 2'b01;
        tick();
        n_checks++; if (q8.count_o !== 4'd1 || q8.rd_data_o[0] !== pl(21)) begin
            n_fail++; $display("FAIL pre_pop01: got count=%0d d0=%h want 1 %h", q8.count_o, q8.rd_data_o[0], pl(21)); end
        n_checks++; if (q8.rd_valid_o !== 2'b01 || q8.rd_data_o[1] !== 32'd0) begin
            n_fail++; $display("FAIL pre_lane1: got valid=%b d1=%h want 01 0", q8.rd_valid_o, q8.rd_data_o[1]); end
        q8.rd_pop_i = 2'b11;
        tick();
        q8.rd_pop_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd0) begin n_fail++; $display("FAIL pre_pop11: got %0d want 0", q8.count_o); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] sb[$];
        int nxt;
        nxt = 100;
        for (int c = 0; c < 10; c++) begin
            q6.wr_valid_i = 2'b11; q6.wr_data_i[0] = pl(nxt); q6.wr_data_i[1] = pl(nxt+1);
            q6.rd_pop_i = 2'b11;
            #1;
            if (sb.size() >= 2) begin
                n_checks++; if (q6.rd_data_o[0] !== sb[0] || q6.rd_data_o[1] !== sb[1]) begin
                    n_fail++; $display("FAIL wrap_data[%0d]: got %h %h want %h %h", c, q6.rd_data_o[0], q6.rd_data_o[1], sb[0], sb[1]); end
            end else begin
                n_checks++; if (q6.rd_valid_o !== 2'b00) begin n_fail++; $display("FAIL wrap_valid0: got %b want 00", q6.rd_valid_o); end
            end
            tick();
            if (sb.size() >= 2) begin
                void'(sb.pop_front());
                void'(sb.pop_front());
            end
            sb.push_back(pl(nxt)); sb.push_back(pl(nxt+1));
            nxt += 2;
            n_checks++; if (int'(q6.count_o) !== sb.size()) begin
                n_fail++; $display("FAIL wrap_count[%0d]: got %0d want %0d", c, q6.count_o, sb.size()); end
        end
        q6.wr_valid_i = 2'b00;
        #1;
        n_checks++; if (q6.rd_data_o[0] !== pl(118) || q6.rd_data_o[1] !== pl(119)) begin
            n_fail++; $display("FAIL wrap_last: got %h %h want %h %h", q6.rd_data_o[0], q6.rd_data_o[1], pl(118), pl(119)); end
        tick();
        q6.rd_pop_i = 2'b00;
        n_checks++; if (q6.empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", q6.empty_o); end
    endtask

    task automatic test_flush();
        push8(2'b11, 30, 31); push8(2'b11, 32, 33); push8(2'b01, 34, 94);
        n_checks++; if (q8.count_o !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", q8.count_o); end
        q8.flush_i = 1'b1; q8.wr_valid_i = 2'b11; q8.wr_data_i[0] = pl(95); q8.wr_data_i[1] = pl(96); q8.rd_pop_i = 2'b11;
        #1;
        n_checks++; if (q8.wr_ready_o !== 2'b00) begin n_fail++; $display("FAIL flush_ready: got %b want 00", q8.wr_ready_o); end
        tick();
        q8.flush_i = 1'b0; q8.wr_valid_i = 2'b00; q8.rd_pop_i = 2'b00;
        n_checks++; if (q8.count_o !== 4'd0 || q8.empty_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_state: got count=%0d empty=%b want 0/1", q8.count_o, q8.empty_o); end
        n_checks++; if (q8.rd_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_rd_valid: got %b want 00", q8.rd_valid_o); end
        push8(2'b11, 40, 41);
        n_checks++; if (q8.count_o !== 4'd2 || q8.rd_data_o[0] !== pl(40) || q8.rd_data_o[1] !== pl(41)) begin
            n_fail++; $display("FAIL flush_after: got count=%0d %h %h want 2 %h %h", q8.count_o, q8.rd_data_o[0], q8.rd_data_o[1], pl(40), pl(41)); end
    endtask

    task automatic test_async_reset();
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (q8.full_o !== 1'b1 || q8.count_o !== 4'd0) begin
            n_fail++; $display("FAIL areset: got full=%b count=%0d want 1/0", q8.full_o, q8.count_o); end
        n_checks++; if (q8.rd_valid_o !== 2'b00) begin n_fail++; $display("FAIL areset_valid: got %b want 00", q8.rd_valid_o); end
        tick();
        rstn = 1'b1;
        #1;
        n_checks++; if (q8.full_o !== 1'b0 || q8.empty_o !== 1'b1) begin
            n_fail++; $display("FAIL areset_release: got full=%b empty=%b want 0/1", q8.full_o, q8.empty_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_partial_push();
        test_prefix();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
